// File: rtl/fb_dac_pkg.sv
// Shared types and constants for the feedback DAC driver.
package fb_dac_pkg;

    localparam int unsigned DIN_W  = 13;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LIM_W  = 12;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned TRIP_W = 4;

    localparam logic [DIN_W-1:0] MIDSCALE = 13'h1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2,
        RAMP   = 2'd3
    } fb_state_e;

endpackage

// File: rtl/fb_dac_clip.sv
// Stage 1: registers the feedback sample with a symmetric clip to +/-clip_lim.
// Ports: clk, rst_n; fb_sgnl/dac_cond input sample and qualifier; clip_lim
// synchronised magnitude; v1/c1/clip1 registered sample, qualifier and clip flag.
module fb_dac_clip
    import fb_dac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [DIN_W-1:0] fb_sgnl,
    input  logic                    dac_cond,
    input  logic [LIM_W-1:0]        clip_lim,
    output logic signed [DIN_W-1:0] v1,
    output logic                    c1,
    output logic                    clip1
);

    logic signed [DIN_W-1:0] lim_pos;
    logic signed [DIN_W-1:0] lim_neg;
    logic signed [DIN_W-1:0] sat_val;
    logic                    sat_hit;

    // clip_lim <= 4095, so the negated limit always fits in DIN_W
    assign lim_pos = signed'({1'b0, clip_lim});
    assign lim_neg = -lim_pos;

    // Saturator
    always_comb begin
        sat_val = fb_sgnl;
        sat_hit = 1'b0;
        if (fb_sgnl > lim_pos) begin
            sat_val = lim_pos;
            sat_hit = 1'b1;
        end else if (fb_sgnl < lim_neg) begin
            sat_val = lim_neg;
            sat_hit = 1'b1;
        end
    end

    // Stage-1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= '0;
            c1    <= 1'b0;
            clip1 <= 1'b0;
        end else begin
            v1    <= sat_val;
            c1    <= dac_cond;
            clip1 <= sat_hit;
        end
    end

endmodule

// File: rtl/fb_dac_driver.sv
// Kicker DAC output stage: clip, hold/ramp-to-zero after each train,
// offset-binary conversion and protection trips with a latched fault.
// Ports: clk, rst_n; fb_sgnl/dac_cond feedback sample; slow-domain config
// enable, clip_lim, hold_len, ramp_step, trip_cnt, max_len, fault_clr;
// outputs dac_data/dac_wr, fault, clip_count, state.
module fb_dac_driver
    import fb_dac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [DIN_W-1:0] fb_sgnl,
    input  logic                    dac_cond,
    input  logic                    enable,
    input  logic [LIM_W-1:0]        clip_lim,
    input  logic [HOLD_W-1:0]       hold_len,
    input  logic [STEP_W-1:0]       ramp_step,
    input  logic [TRIP_W-1:0]       trip_cnt,
    input  logic [CNT_W-1:0]        max_len,
    input  logic                    fault_clr,
    output logic [DIN_W-1:0]        dac_data,
    output logic                    dac_wr,
    output logic                    fault,
    output logic [CNT_W-1:0]        clip_count,
    output logic [1:0]              state
);

    // Slow-domain synchronisers
    logic              en_s1, en_s2;
    logic [LIM_W-1:0]  lim_s1, lim_s2;
    logic [HOLD_W-1:0] hold_s1, hold_s2;
    logic [STEP_W-1:0] step_s1, step_s2;
    logic [TRIP_W-1:0] trip_s1, trip_s2;
    logic [CNT_W-1:0]  max_s1, max_s2;
    logic              clr_s1, clr_s2, clr_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1   <= 1'b0; en_s2   <= 1'b0;
            lim_s1  <= '0;   lim_s2  <= '0;
            hold_s1 <= '0;   hold_s2 <= '0;
            step_s1 <= '0;   step_s2 <= '0;
            trip_s1 <= '0;   trip_s2 <= '0;
            max_s1  <= '0;   max_s2  <= '0;
            clr_s1  <= 1'b0; clr_s2  <= 1'b0; clr_s3 <= 1'b0;
        end else begin
            en_s1   <= enable;    en_s2   <= en_s1;
            lim_s1  <= clip_lim;  lim_s2  <= lim_s1;
            hold_s1 <= hold_len;  hold_s2 <= hold_s1;
            step_s1 <= ramp_step; step_s2 <= step_s1;
            trip_s1 <= trip_cnt;  trip_s2 <= trip_s1;
            max_s1  <= max_len;   max_s2  <= max_s1;
            clr_s1  <= fault_clr; clr_s2  <= clr_s1; clr_s3 <= clr_s2;
        end
    end

    logic clr_edge;
    assign clr_edge = clr_s2 & ~clr_s3;

    // Stage 1
    logic signed [DIN_W-1:0] v1;
    logic                    c1;
    logic                    clip1;

    fb_dac_clip u_clip (
        .clk      (clk),
        .rst_n    (rst_n),
        .fb_sgnl  (fb_sgnl),
        .dac_cond (dac_cond),
        .clip_lim (lim_s2),
        .v1       (v1),
        .c1       (c1),
        .clip1    (clip1)
    );

    // Stage 2 state
    fb_state_e               state_q, state_d;
    logic signed [DIN_W-1:0] val_q, val_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [TRIP_W-1:0]       run_q, run_d;
    logic [CNT_W-1:0]        cc_d;
    logic                    fault_d;
    logic [DIN_W-1:0]        dac_d;
    logic                    wr_d;

    // One ramp step toward zero; done when the remaining magnitude fits in one step
    logic [DIN_W-1:0]        mag;
    logic signed [DIN_W-1:0] step_ext;
    logic signed [DIN_W-1:0] ramp_val;
    logic                    ramp_done;

    assign mag       = val_q[DIN_W-1] ? DIN_W'(-val_q) : DIN_W'(val_q);
    assign step_ext  = signed'(DIN_W'(step_s2));
    assign ramp_done = (step_s2 == '0) || (mag <= DIN_W'(step_s2));
    assign ramp_val  = ramp_done ? '0 :
                       (val_q[DIN_W-1] ? (val_q + step_ext) : (val_q - step_ext));

    logic go;
    logic accept;
    logic do_ramp;
    logic trip;

    assign go = c1 & en_s2;

    // Next-state and datapath decisions
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        hold_d  = '0;
        len_d   = '0;
        run_d   = '0;
        cc_d    = clip_count;
        accept  = 1'b0;
        do_ramp = 1'b0;
        trip    = 1'b0;

        if (fault) begin
            state_d = IDLE;
            val_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    val_d = '0;
                    if (go) accept = 1'b1;
                end
                ACTIVE: begin
                    if (!en_s2) begin
                        do_ramp = 1'b1;
                    end else if (!c1) begin
                        if (hold_s2 == '0) begin
                            do_ramp = 1'b1;
                        end else begin
                            state_d = HOLD;
                            hold_d  = HOLD_W'(1);
                        end
                    end else begin
                        accept = 1'b1;
                    end
                end
                HOLD: begin
                    if (go) begin
                        accept = 1'b1;
                    end else if (hold_q >= hold_s2) begin
                        do_ramp = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                RAMP: begin
                    if (go) accept = 1'b1;
                    else    do_ramp = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    val_d   = '0;
                end
            endcase
        end

        if (do_ramp) begin
            val_d   = ramp_val;
            state_d = ramp_done ? IDLE : RAMP;
        end

        // Length and clip-run counters restart on every entry to ACTIVE
        if (accept) begin
            state_d = ACTIVE;
            val_d   = v1;
            if (state_q == ACTIVE) begin
                len_d = (len_q == '1) ? len_q : len_q + CNT_W'(1);
                run_d = !clip1 ? '0 : ((run_q == '1) ? run_q : run_q + TRIP_W'(1));
            end else begin
                len_d = CNT_W'(1);
                run_d = clip1 ? TRIP_W'(1) : '0;
            end
            if (clip1 && clip_count != '1) cc_d = clip_count + CNT_W'(1);
            trip = ((trip_s2 != '0) && (run_d == trip_s2)) ||
                   ((max_s2 != '0) && (len_d == max_s2));
        end

        // A trip coinciding with a clear keeps the fault set
        fault_d = trip ? 1'b1 : (clr_edge ? 1'b0 : fault);
        dac_d   = val_d ^ MIDSCALE;
        wr_d    = (state_d != IDLE);
    end

    // Stage-2 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            val_q      <= '0;
            hold_q     <= '0;
            len_q      <= '0;
            run_q      <= '0;
            clip_count <= '0;
            fault      <= 1'b0;
            dac_data   <= MIDSCALE;
            dac_wr     <= 1'b0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            run_q      <= run_d;
            clip_count <= cc_d;
            fault      <= fault_d;
            dac_data   <= dac_d;
            dac_wr     <= wr_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_fb_dac_driver.sv
// Directed bench for fb_dac_driver: table-driven train vectors plus
// hand-written sequences for fault clear, length trip and async reset.
module tb_fb_dac_driver;

    logic               clk;
    logic               rst_n;
    logic signed [12:0] fb_sgnl;
    logic               dac_cond;
    logic               enable;
    logic [11:0]        clip_lim;
    logic [7:0]         hold_len;
    logic [7:0]         ramp_step;
    logic [3:0]         trip_cnt;
    logic [15:0]        max_len;
    logic               fault_clr;
    logic [12:0]        dac_data;
    logic               dac_wr;
    logic               fault;
    logic [15:0]        clip_count;
    logic [1:0]         state;

    fb_dac_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fb_sgnl    (fb_sgnl),
        .dac_cond   (dac_cond),
        .enable     (enable),
        .clip_lim   (clip_lim),
        .hold_len   (hold_len),
        .ramp_step  (ramp_step),
        .trip_cnt   (trip_cnt),
        .max_len    (max_len),
        .fault_clr  (fault_clr),
        .dac_data   (dac_data),
        .dac_wr     (dac_wr),
        .fault      (fault),
        .clip_count (clip_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [12:0] fb;
        logic               cond;
        logic [12:0]        dac;
        logic               wr;
        logic               flt;
    } vec_t;

    vec_t tv [30];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input int fb, input bit c, input int dac,
                        input bit wr, input bit flt);
        tv[i].fb   = 13'(fb);
        tv[i].cond = c;
        tv[i].dac  = 13'(dac);
        tv[i].wr   = wr;
        tv[i].flt  = flt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int lim, input int hl, input int stp, input int trp,
                       input int mx);
        fb_sgnl   = '0;
        dac_cond  = 1'b0;
        enable    = 1'b1;
        clip_lim  = 12'(lim);
        hold_len  = 8'(hl);
        ramp_step = 8'(stp);
        trip_cnt  = 4'(trp);
        max_len   = 16'(mx);
        repeat (5) tick();
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            fb_sgnl  = tv[i].fb;
            dac_cond = tv[i].cond;
            tick();
            chk($sformatf("row%0d dac", i), int'(dac_data), int'(tv[i].dac));
            chk($sformatf("row%0d wr", i), int'(dac_wr), int'(tv[i].wr));
            chk($sformatf("row%0d fault", i), int'(fault), int'(tv[i].flt));
        end
    endtask

    task automatic pulse_clear();
        fault_clr = 1'b1;
        repeat (3) tick();
        fault_clr = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int  act_cnt;
        int  bad_mid;
        bit  seen;
        bit  got_wr;

        // Pass-through, limit wide open, ramp straight after the train
        setv(0, 100, 1, 'h1000, 0, 0);
        setv(1, -200, 1, 'h1064, 1, 0);
        setv(2, 300, 1, 'h0F38, 1, 0);
        setv(3, -400, 1, 'h112C, 1, 0);
        setv(4, 0, 0, 'h0E70, 1, 0);
        setv(5, 0, 0, 'h0F6F, 1, 0);   // -400 + 255 = -145
        setv(6, 0, 0, 'h1000, 0, 0);
        setv(7, 0, 0, 'h1000, 0, 0);
        // Clip at +/-1000, then ramp from -1000 in steps of 255
        setv(8, 3000, 1, 'h1000, 0, 0);
        setv(9, -4096, 1, 'h13E8, 1, 0);
        setv(10, 0, 0, 'h0C18, 1, 0);
        setv(11, 0, 0, 'h0D17, 1, 0);  // -745
        setv(12, 0, 0, 'h0E16, 1, 0);  // -490
        setv(13, 0, 0, 'h0F15, 1, 0);  // -235
        setv(14, 0, 0, 'h1000, 0, 0);
        // Hold 3 cycles after the train, ramp by 200
        setv(15, 500, 1, 'h1000, 0, 0);
        setv(16, 0, 0, 'h11F4, 1, 0);
        setv(17, 0, 0, 'h11F4, 1, 0);
        setv(18, 0, 0, 'h11F4, 1, 0);
        setv(19, 0, 0, 'h11F4, 1, 0);
        setv(20, 0, 0, 'h112C, 1, 0);
        setv(21, 0, 0, 'h1064, 1, 0);
        setv(22, 0, 0, 'h1000, 0, 0);
        // Clip trip after three clipped samples; later dac_cond ignored
        setv(23, 500, 1, 'h1000, 0, 0);
        setv(24, 500, 1, 'h1064, 1, 0);
        setv(25, 500, 1, 'h1064, 1, 0);
        setv(26, 500, 1, 'h1064, 1, 1);
        setv(27, 500, 1, 'h1000, 0, 1);
        setv(28, 500, 1, 'h1000, 0, 1);
        setv(29, 0, 0, 'h1000, 0, 1);

        rst_n = 1'b0; fb_sgnl = '0; dac_cond = 1'b0; enable = 1'b0;
        clip_lim = '0; hold_len = '0; ramp_step = '0; trip_cnt = '0;
        max_len = '0; fault_clr = 1'b0;
        #22;
        chk("rst dac", int'(dac_data), 'h1000);
        chk("rst wr", int'(dac_wr), 0);
        chk("rst fault", int'(fault), 0);
        chk("rst clip_count", int'(clip_count), 0);
        chk("rst state", int'(state), 0);
        rst_n = 1'b1;

        cfg(4095, 0, 255, 0, 0);
        run_rows(0, 7);

        cfg(1000, 0, 255, 0, 0);
        run_rows(8, 14);
        chk("clip_count after clip", int'(clip_count), 2);

        cfg(4095, 3, 200, 0, 0);
        run_rows(15, 22);
        chk("state idle after ramp", int'(state), 0);

        cfg(100, 0, 255, 3, 0);
        run_rows(23, 29);
        chk("clip_count after trip", int'(clip_count), 5);
        pulse_clear();
        chk("fault cleared", int'(fault), 0);
        fb_sgnl = 13'sd50; dac_cond = 1'b1;
        tick();
        dac_cond = 1'b0;
        tick();
        chk("post-clear dac", int'(dac_data), 'h1032);
        chk("post-clear wr", int'(dac_wr), 1);

        // Length trip: 20 cycles of dac_cond, max_len 10
        cfg(4095, 0, 255, 0, 10);
        act_cnt = 0; bad_mid = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            fb_sgnl = 13'(i + 1); dac_cond = 1'b1;
            tick();
            if (!seen) begin
                if (dac_wr) act_cnt++;
                if (fault) begin
                    seen = 1'b1;
                    chk("len trip active cycles", act_cnt, 10);
                    chk("len trip last sample", int'(dac_data), 'h100A);
                end
            end else if (dac_data != 13'h1000 || dac_wr) begin
                bad_mid++;
            end
        end
        dac_cond = 1'b0;
        chk("len trip seen", int'(seen), 1);
        chk("len trip midscale after", bad_mid, 0);
        tick();
        chk("len trip fault held", int'(fault), 1);
        pulse_clear();
        chk("len fault cleared", int'(fault), 0);

        // Async reset in the middle of a train
        cfg(4095, 0, 255, 0, 0);
        fb_sgnl = 13'sd777; dac_cond = 1'b1;
        repeat (3) tick();
        chk("pre-reset dac", int'(dac_data), 'h1309);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async dac", int'(dac_data), 'h1000);
        chk("async wr", int'(dac_wr), 0);
        chk("async fault", int'(fault), 0);
        chk("async clip_count", int'(clip_count), 0);
        chk("async state", int'(state), 0);
        tick();
        rst_n = 1'b1;
        got_wr = 1'b0;
        for (int i = 0; i < 10 && !got_wr; i++) begin
            tick();
            got_wr = dac_wr;
        end
        chk("resume wr", int'(got_wr), 1);
        tick();
        chk("resume dac", int'(dac_data), 'h1309);
        dac_cond = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
